// File: rtl/divn_seq_pkg.sv
// ============================================================================
// Module      : divn_seq_pkg
// Description : Shared types and helpers for the sequential restoring divider:
//               FSM state encoding and the iteration-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package divn_seq_pkg;

  // Divider FSM state encoding (fixed values, shared with the control unit)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal operand width range
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Counter must be able to hold the value WIDTH itself
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/divn_seq_if.sv
// ============================================================================
// Module      : divn_seq_if
// Description : start/busy/done handshake and operand/result bus between the
//               control unit (master) and the divider (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface divn_seq_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  // Control unit side: issues requests, observes status and results
  modport master (
    output start, A, B,
    input  busy, done, quotient, remainder, div_zero
  );

  // Divider side
  modport slave (
    input  start, A, B,
    output busy, done, quotient, remainder, div_zero
  );

endinterface

`default_nettype wire

// File: rtl/subn.sv
// ============================================================================
// Module      : subn
// Description : Parametrised two's-complement subtractor built as an inverter
//               stage followed by a ripple-carry adder with carry-in of 1:
//               diff = A + ~B + 1. c_out = 1 means no borrow (A >= B).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subn #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] diff,
  output logic             c_out
);

  logic [WIDTH-1:0] b_n;

  // Inverter stage (one's complement of the subtrahend)
  assign b_n = ~B;

  // Ripple-carry full-adder chain; the +1 enters as the initial carry
  always_comb begin
    logic carry;
    carry = 1'b1;
    diff  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = A[i] ^ b_n[i] ^ carry;
      carry   = (A[i] & b_n[i]) | (carry & (A[i] ^ b_n[i]));
    end
    c_out = carry;
  end

endmodule

`default_nettype wire

// File: rtl/divn_seq.sv
// ============================================================================
// Module      : divn_seq
// Description : Sequential unsigned restoring divider. Accepts A/B on a start
//               handshake, performs one trial subtract-and-shift per clock for
//               WIDTH clocks, then pulses done with registered quotient and
//               remainder. B==0 completes immediately with div_zero set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divn_seq
  import divn_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  divn_seq_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  // Working registers
  state_t             state;
  logic [WIDTH-1:0]   d;          // dividend, becomes quotient as it shifts
  logic [WIDTH-1:0]   v;          // divisor
  logic [WIDTH:0]     r;          // partial remainder
  logic [CNT_W-1:0]   cnt;        // completed iterations

  // Registered outputs
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;
  logic               div_zero_q;

  // Trial-subtraction datapath
  logic [WIDTH:0]     t;
  logic [WIDTH:0]     s;
  logic               no_borrow;
  logic [WIDTH:0]     r_next;
  logic [WIDTH-1:0]   d_next;

  // The restored remainder is always below the divisor, so its top bit is
  // never needed to form the next trial value.
  logic               unused_r_msb;
  assign unused_r_msb = r[WIDTH];

  // Bring down the next dividend bit next to the current partial remainder
  assign t = {r[WIDTH-1:0], d[WIDTH-1]};

  subn #(
    .WIDTH (WIDTH + 1)
  ) u_subn (
    .A     (t),
    .B     ({1'b0, v}),
    .diff  (s),
    .c_out (no_borrow)
  );

  // Keep the difference only when it did not borrow; quotient bit follows
  assign r_next = no_borrow ? s : t;
  assign d_next = {d[WIDTH-2:0], no_borrow};

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      d           <= '0;
      v           <= '0;
      r           <= '0;
      cnt         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            d   <= bus.A;
            v   <= bus.B;
            r   <= '0;
            cnt <= '0;
            if (bus.B == '0) begin
              // Divide-by-zero completes on the accepting edge
              state       <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= bus.A;
              div_zero_q  <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r   <= r_next;
          d   <= d_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= d_next;
            remainder_q <= r_next[WIDTH-1:0];
            div_zero_q  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_divn_seq.sv
// ============================================================================
// Module      : tb_divn_seq
// Description : Self-checking bench for divn_seq at WIDTH=8 and WIDTH=16.
//               Expected results come from plain integer division.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divn_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  divn_seq_if #(.WIDTH(8))  bus8 ();
  divn_seq_if #(.WIDTH(16)) bus16 ();

  divn_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  divn_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  // ---------------- observation helpers (no comparisons) -----------------
  function automatic logic cur_done(input bit wide);
    return wide ? bus16.done : bus8.done;
  endfunction
  function automatic logic cur_busy(input bit wide);
    return wide ? bus16.busy : bus8.busy;
  endfunction
  function automatic logic [15:0] cur_q(input bit wide);
    return wide ? bus16.quotient : {8'h00, bus8.quotient};
  endfunction
  function automatic logic [15:0] cur_r(input bit wide);
    return wide ? bus16.remainder : {8'h00, bus8.remainder};
  endfunction
  function automatic logic cur_dz(input bit wide);
    return wide ? bus16.div_zero : bus8.div_zero;
  endfunction

  // Drive start with operands through one accepting edge
  task automatic start_op(input bit wide, input logic [15:0] a, input logic [15:0] b);
    if (wide) begin
      bus16.start = 1'b1; bus16.A = a; bus16.B = b;
    end else begin
      bus8.start = 1'b1; bus8.A = a[7:0]; bus8.B = b[7:0];
    end
    @(posedge clk); #1;
    bus8.start = 1'b0; bus16.start = 1'b0;
    bus8.A = 8'($urandom); bus8.B = 8'($urandom);
    bus16.A = 16'($urandom); bus16.B = 16'($urandom);
  endtask

  // Wait (bounded) for done; counts edges after acceptance and busy cycles
  task automatic wait_op(input bit wide, output int edges, output int busy_cyc,
                         output bit timed_out, output bit held);
    logic [15:0] q0;
    edges = 0; busy_cyc = 0; timed_out = 1'b0; held = 1'b1;
    q0 = cur_q(wide);
    while (!cur_done(wide)) begin
      if (cur_busy(wide)) busy_cyc++;
      if (cur_q(wide) !== q0) held = 1'b0;
      if (edges >= 100) begin timed_out = 1'b1; break; end
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // Full operation with model comparison
  task automatic run_and_check(input string name, input bit wide,
                               input logic [15:0] a, input logic [15:0] b);
    int w, edges, bc;
    bit to, held;
    logic [15:0] eq, er, mask;
    logic edz;
    w    = wide ? 16 : 8;
    mask = wide ? 16'hFFFF : 16'h00FF;
    if (b == 0) begin eq = mask; er = a; edz = 1'b1; end
    else begin eq = a / b; er = a % b; edz = 1'b0; end
    start_op(wide, a, b);
    wait_op(wide, edges, bc, to, held);
    checks++;
    if (to) begin
      fails++; $display("FAIL %s timeout: no done within 100 cycles", name);
    end else begin
      checks++;
      if (edges !== ((b == 0) ? 0 : w)) begin
        fails++; $display("FAIL %s latency: got %0d expected %0d", name, edges, (b == 0) ? 0 : w);
      end
      checks++;
      if (bc !== ((b == 0) ? 0 : w)) begin
        fails++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, (b == 0) ? 0 : w);
      end
      checks++;
      if (cur_q(wide) !== eq || cur_r(wide) !== er || cur_dz(wide) !== edz) begin
        fails++;
        $display("FAIL %s result: got q=%0d r=%0d dz=%0b expected q=%0d r=%0d dz=%0b",
                 name, cur_q(wide), cur_r(wide), cur_dz(wide), eq, er, edz);
      end
      checks++;
      if (!held) begin
        fails++; $display("FAIL %s hold: quotient changed during RUN, got changed expected stable", name);
      end
      if (b != 0) begin
        checks++;
        if (cur_q(wide) * b + cur_r(wide) !== a || cur_r(wide) >= b) begin
          fails++;
          $display("FAIL %s invariant: got q*b+r=%0d r=%0d expected %0d with r<%0d",
                   name, cur_q(wide) * b + cur_r(wide), cur_r(wide), a, b);
        end
      end
    end
  endtask

  // ------------------------------- tests ---------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0;
    bus16.start = 1'b0; bus16.A = '0; bus16.B = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({bus8.busy, bus8.done, bus8.div_zero} !== 3'b000 || bus8.quotient !== 8'd0 || bus8.remainder !== 8'd0) begin
      fails++; $display("FAIL reset8: got busy=%0b done=%0b q=%0d r=%0d dz=%0b expected all 0",
                        bus8.busy, bus8.done, bus8.quotient, bus8.remainder, bus8.div_zero);
    end
    checks++;
    if ({bus16.busy, bus16.done, bus16.div_zero} !== 3'b000 || bus16.quotient !== 16'd0 || bus16.remainder !== 16'd0) begin
      fails++; $display("FAIL reset16: got busy=%0b done=%0b q=%0d r=%0d expected all 0",
                        bus16.busy, bus16.done, bus16.quotient, bus16.remainder);
    end
  endtask

  task automatic test_basic();
    run_and_check("div_100_7", 1'b0, 16'd100, 16'd7);
    checks++;
    if (bus8.quotient !== 8'd14 || bus8.remainder !== 8'd2) begin
      fails++; $display("FAIL basic_const: got q=%0d r=%0d expected q=14 r=2", bus8.quotient, bus8.remainder);
    end
    @(posedge clk); #1;
    checks++;
    if (bus8.done !== 1'b0) begin
      fails++; $display("FAIL done_pulse: got done=%0b expected 0 one cycle later", bus8.done);
    end
    run_and_check("div_3_10", 1'b0, 16'd3, 16'd10);
    run_and_check("div_255_1", 1'b0, 16'd255, 16'd1);
  endtask

  task automatic test_div_zero();
    run_and_check("div_5_0", 1'b0, 16'd5, 16'd0);
    checks++;
    if (bus8.quotient !== 8'hFF || bus8.remainder !== 8'd5 || bus8.div_zero !== 1'b1) begin
      fails++; $display("FAIL div0_const: got q=%0h r=%0d dz=%0b expected q=ff r=5 dz=1",
                        bus8.quotient, bus8.remainder, bus8.div_zero);
    end
    @(posedge clk); #1;
    run_and_check("div_20_4", 1'b0, 16'd20, 16'd4);
  endtask

  task automatic test_ignored_start();
    int edges, bc;
    bit to, held;
    start_op(1'b0, 16'd200, 16'd3);
    repeat (2) @(posedge clk);
    #1;
    bus8.start = 1'b1; bus8.A = 8'd9; bus8.B = 8'd2;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_op(1'b0, edges, bc, to, held);
    checks++;
    if (to || edges + 3 !== 8 || bus8.quotient !== 8'd66 || bus8.remainder !== 8'd2) begin
      fails++; $display("FAIL ignored_start: got latency=%0d q=%0d r=%0d expected latency=8 q=66 r=2",
                        edges + 3, bus8.quotient, bus8.remainder);
    end
  endtask

  task automatic test_back_to_back();
    // Previous test returns in its done cycle; start now is accepted at DONE
    start_op(1'b0, 16'd9, 16'd2);
    checks++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b1) begin
      fails++; $display("FAIL b2b_accept: got done=%0b busy=%0b expected done=0 busy=1", bus8.done, bus8.busy);
    end
    begin
      int edges, bc;
      bit to, held;
      wait_op(1'b0, edges, bc, to, held);
      checks++;
      if (to || edges !== 8 || bus8.quotient !== 8'd4 || bus8.remainder !== 8'd1) begin
        fails++; $display("FAIL b2b_result: got latency=%0d q=%0d r=%0d expected latency=8 q=4 r=1",
                          edges, bus8.quotient, bus8.remainder);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_op(1'b0, 16'd77, 16'd5);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({bus8.busy, bus8.done, bus8.div_zero} !== 3'b000 || bus8.quotient !== 8'd0 ||
        bus8.remainder !== 8'd0 || dut8.state !== 2'd0) begin
      fails++; $display("FAIL reset_mid: got busy=%0b done=%0b q=%0d r=%0d state=%0d expected all 0",
                        bus8.busy, bus8.done, bus8.quotient, bus8.remainder, dut8.state);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      fails++; $display("FAIL reset_no_done: got done pulse expected none");
    end
    run_and_check("div_77_5", 1'b0, 16'd77, 16'd5);
    @(posedge clk); #1;
  endtask

  task automatic test_wide_random();
    logic [15:0] a, b;
    run_and_check("div16_65535_255", 1'b1, 16'd65535, 16'd255);
    checks++;
    if (bus16.quotient !== 16'd257 || bus16.remainder !== 16'd0) begin
      fails++; $display("FAIL wide_const: got q=%0d r=%0d expected q=257 r=0", bus16.quotient, bus16.remainder);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 500; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(0, 15));
        1:       b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      run_and_check("rand16", 1'b1, a, b);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 100; i++) begin
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 255));
      run_and_check("rand8", 1'b0, a, b);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    @(posedge clk); #1;
    test_div_zero();
    @(posedge clk); #1;
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_wide_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
